// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle between the datapath and pipe_hazard_ctrl.
// Master drives the pipeline status; slave returns controls and forward selects.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              branch_taken;
  logic              mem_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              pipe_en;
  logic              hazard_mux;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_rs, ex_rt, ex_rd, ex_memread,
    output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output branch_taken, mem_busy,
    input  pc_write, ifid_write, pipe_en, hazard_mux,
    input  flush_ifid, flush_idex, flush_exmem,
    input  forward_a, forward_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_rs, ex_rt, ex_rd, ex_memread,
    input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  branch_taken, mem_busy,
    output pc_write, ifid_write, pipe_en, hazard_mux,
    output flush_ifid, flush_idex, flush_exmem,
    output forward_a, forward_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-control unit for the 5-stage core:
// multi-cycle load-use stalls, branch flush, memory freeze, perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz_if
);

  typedef enum logic {RUN, LSTALL} state_e;

  localparam logic [2:0] LAT_INIT =
    3'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

  state_e           state_q, state_d;
  logic [2:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic is_zero(
    input logic [REG_AW-1:0] r
  );
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  function automatic logic hz(input logic [REG_AW-1:0] r);
    return (r == hz_if.ex_rd) && hz_if.ex_memread
      && !is_zero(r);
  endfunction

  function automatic logic [1:0] fwd(
    input logic [REG_AW-1:0] src
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (hz_if.mem_regwrite && hz_if.mem_rd == src
        && !is_zero(src))
      sel = 2'b10;
    else if (hz_if.wb_regwrite && hz_if.wb_rd == src
             && !is_zero(src))
      sel = 2'b01;
    return sel;
  endfunction

  logic load_use;
  logic do_rst, do_frz, do_br, do_ls, do_run;
  logic stall_inc, flush_inc;

  assign load_use =
    (hz_if.id_use_rs && hz(hz_if.id_rs)) ||
    (hz_if.id_use_rt && hz(hz_if.id_rt));

  // One-hot case select encoding the priority chain
  assign do_rst = reset;
  assign do_frz = !reset && hz_if.mem_busy;
  assign do_br  = !reset && !hz_if.mem_busy
    && hz_if.branch_taken;
  assign do_ls  = !reset && !hz_if.mem_busy
    && !hz_if.branch_taken
    && (state_q == LSTALL || load_use);
  assign do_run = !do_rst && !do_frz && !do_br && !do_ls;

  always_comb begin
    hz_if.pc_write    = 1'b1;
    hz_if.ifid_write  = 1'b1;
    hz_if.pipe_en     = 1'b1;
    hz_if.hazard_mux  = 1'b0;
    hz_if.flush_ifid  = 1'b0;
    hz_if.flush_idex  = 1'b0;
    hz_if.flush_exmem = 1'b0;
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (1'b1)
      do_rst: begin
        hz_if.pc_write    = 1'b0;
        hz_if.ifid_write  = 1'b0;
        hz_if.hazard_mux  = 1'b1;
        hz_if.flush_ifid  = 1'b1;
        hz_if.flush_idex  = 1'b1;
        hz_if.flush_exmem = 1'b1;
        state_d = RUN;
        lcnt_d  = 3'd0;
      end
      do_frz: begin
        hz_if.pc_write   = 1'b0;
        hz_if.ifid_write = 1'b0;
        hz_if.pipe_en    = 1'b0;
        stall_inc = 1'b1;
      end
      do_br: begin
        hz_if.flush_ifid  = 1'b1;
        hz_if.flush_idex  = 1'b1;
        hz_if.flush_exmem = 1'b1;
        state_d   = RUN;
        lcnt_d    = 3'd0;
        flush_inc = 1'b1;
      end
      do_ls: begin
        hz_if.pc_write   = 1'b0;
        hz_if.ifid_write = 1'b0;
        hz_if.hazard_mux = 1'b1;
        stall_inc = 1'b1;
        if (state_q == RUN) begin
          if (LOAD_LAT > 1) begin
            state_d = LSTALL;
            lcnt_d  = LAT_INIT;
          end
        end else if (lcnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          lcnt_d = lcnt_q - 3'd1;
        end
      end
      do_run: begin
      end
    endcase
  end

  always_comb begin
    hz_if.forward_a = 2'b00;
    hz_if.forward_b = 2'b00;
    if (!reset) begin
      hz_if.forward_a = fwd(hz_if.ex_rs);
      hz_if.forward_b = fwd(hz_if.ex_rt);
    end
  end

  // Counters saturate at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      lcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz_if.stall_cnt = stall_cnt_q;
  assign hz_if.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT 1 / 3, CNT_W 16 / 4)
// share one stimulus stream and are compared against a bubble-count model.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd;
  logic [4:0] mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, ex_memread;
  logic mem_regwrite, wb_regwrite;
  logic branch_taken, mem_busy;

  int checks = 0;
  int errors = 0;

  int lat[2]  = '{1, 3};
  int cmax[2] = '{65535, 15};
  int rem[2];
  int sc[2];
  int fc[2];

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if0 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if1 ();

  assign if0.id_rs = id_rs;
  assign if0.id_rt = id_rt;
  assign if0.id_use_rs = id_use_rs;
  assign if0.id_use_rt = id_use_rt;
  assign if0.ex_rs = ex_rs;
  assign if0.ex_rt = ex_rt;
  assign if0.ex_rd = ex_rd;
  assign if0.ex_memread = ex_memread;
  assign if0.mem_rd = mem_rd;
  assign if0.mem_regwrite = mem_regwrite;
  assign if0.wb_rd = wb_rd;
  assign if0.wb_regwrite = wb_regwrite;
  assign if0.branch_taken = branch_taken;
  assign if0.mem_busy = mem_busy;

  assign if1.id_rs = id_rs;
  assign if1.id_rt = id_rt;
  assign if1.id_use_rs = id_use_rs;
  assign if1.id_use_rt = id_use_rt;
  assign if1.ex_rs = ex_rs;
  assign if1.ex_rt = ex_rt;
  assign if1.ex_rd = ex_rd;
  assign if1.ex_memread = ex_memread;
  assign if1.mem_rd = mem_rd;
  assign if1.mem_regwrite = mem_regwrite;
  assign if1.wb_rd = wb_rd;
  assign if1.wb_regwrite = wb_regwrite;
  assign if1.branch_taken = branch_taken;
  assign if1.mem_busy = mem_busy;

  pipe_hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(16)
  ) u0 (
    .clock(clock), .reset(reset), .hz_if(if0.slave)
  );

  pipe_hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(4)
  ) u1 (
    .clock(clock), .reset(reset), .hz_if(if1.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic lu();
    logic a, b;
    a = id_use_rs && ex_memread && id_rs == ex_rd
        && id_rs != 0;
    b = id_use_rt && ex_memread && id_rt == ex_rd
        && id_rt != 0;
    return a || b;
  endfunction

  // {pc_write, ifid_write, pipe_en, hazard_mux, fl_ifid, fl_idex, fl_exmem}
  function automatic logic [6:0] exp_ctl(input int r);
    if (reset) return 7'b0011111;
    if (mem_busy) return 7'b0000000;
    if (branch_taken) return 7'b1110111;
    if (r > 0 || lu()) return 7'b0011000;
    return 7'b1110000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] s);
    if (reset || s == 0) return 2'b00;
    if (mem_regwrite && mem_rd == s) return 2'b10;
    if (wb_regwrite && wb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_cycle();
    chk("ctl0", {if0.pc_write, if0.ifid_write, if0.pipe_en,
      if0.hazard_mux, if0.flush_ifid, if0.flush_idex,
      if0.flush_exmem}, 32'(exp_ctl(rem[0])));
    chk("ctl1", {if1.pc_write, if1.ifid_write, if1.pipe_en,
      if1.hazard_mux, if1.flush_ifid, if1.flush_idex,
      if1.flush_exmem}, 32'(exp_ctl(rem[1])));
    chk("fa0", 32'(if0.forward_a), 32'(exp_fwd(ex_rs)));
    chk("fb0", 32'(if0.forward_b), 32'(exp_fwd(ex_rt)));
    chk("fa1", 32'(if1.forward_a), 32'(exp_fwd(ex_rs)));
    chk("fb1", 32'(if1.forward_b), 32'(exp_fwd(ex_rt)));
    chk("sc0", 32'(if0.stall_cnt), 32'(sc[0]));
    chk("fc0", 32'(if0.flush_cnt), 32'(fc[0]));
    chk("sc1", 32'(if1.stall_cnt), 32'(sc[1]));
    chk("fc1", 32'(if1.flush_cnt), 32'(fc[1]));
  endtask

  task automatic model_update();
    logic l;
    l = lu();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        rem[k] = 0; sc[k] = 0; fc[k] = 0;
      end else if (mem_busy) begin
        if (sc[k] < cmax[k]) sc[k]++;
      end else if (branch_taken) begin
        rem[k] = 0;
        if (fc[k] < cmax[k]) fc[k]++;
      end else if (rem[k] > 0 || l) begin
        if (sc[k] < cmax[k]) sc[k]++;
        if (rem[k] > 0) rem[k]--;
        else rem[k] = lat[k] - 1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic quiet();
    reset = 0;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    branch_taken = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic load_use1();
    ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    cyc();
    quiet();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; sc[k] = 0; fc[k] = 0;
    end
    quiet();
    reset = 1;
    #1;
    cyc();
    cyc();
    chk("rst_pc", 32'(if0.pc_write), 32'd0);
    chk("rst_fl", 32'({if1.flush_ifid, if1.flush_idex,
      if1.flush_exmem}), 32'd7);
    chk("rst_sc", 32'(if0.stall_cnt), 32'd0);
    quiet();
    cyc();
    chk("run_pc", 32'({if0.pc_write, if0.ifid_write,
      if0.pipe_en}), 32'd7);

    ex_rs = 3; mem_rd = 3; mem_regwrite = 1;
    wb_rd = 3; wb_regwrite = 1;
    cyc();
    chk("fwd_mem", 32'(if0.forward_a), 32'b10);
    mem_regwrite = 0;
    cyc();
    chk("fwd_wb", 32'(if0.forward_a), 32'b01);
    ex_rs = 0; mem_regwrite = 1; mem_rd = 0; wb_rd = 0;
    cyc();
    chk("fwd_zero", 32'(if0.forward_a), 32'b00);

    do_reset();
    load_use1();
    repeat (4) cyc();
    chk("lu_lat1", 32'(if0.stall_cnt), 32'd1);
    chk("lu_lat3", 32'(if1.stall_cnt), 32'd3);

    do_reset();
    load_use1();
    branch_taken = 1;
    cyc();
    quiet();
    repeat (3) cyc();
    chk("br_fc0", 32'(if0.flush_cnt), 32'd1);
    chk("br_fc1", 32'(if1.flush_cnt), 32'd1);
    chk("br_sc1", 32'(if1.stall_cnt), 32'd1);

    do_reset();
    load_use1();
    mem_busy = 1;
    repeat (4) cyc();
    mem_busy = 0;
    repeat (4) cyc();
    chk("frz_sc0", 32'(if0.stall_cnt), 32'd5);
    chk("frz_sc1", 32'(if1.stall_cnt), 32'd7);
    mem_busy = 1; branch_taken = 1;
    repeat (3) cyc();
    chk("frz_br", 32'(if1.flush_cnt), 32'd0);
    mem_busy = 0;
    cyc();
    quiet();
    cyc();
    chk("frz_brdone", 32'(if1.flush_cnt), 32'd1);

    do_reset();
    mem_busy = 1;
    repeat (20) cyc();
    quiet();
    cyc();
    chk("sat1", 32'(if1.stall_cnt), 32'd15);
    chk("sat0", 32'(if0.stall_cnt), 32'd20);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      ex_rs = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_memread = ($urandom_range(0, 2) == 0);
      mem_rd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3));
      wb_regwrite = 1'($urandom);
      branch_taken = ($urandom_range(0, 9) == 0);
      mem_busy = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
